// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI-flash responder: opcodes, FSM encodings and the JEDEC byte picker.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FAST  = 8'h0B;
    localparam logic [7:0] OP_JEDEC = 8'h9F;

    localparam int unsigned DUMMY_BITS = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_ADDR   = 3'd2;
    localparam state_t ST_DUMMY  = 3'd3;
    localparam state_t ST_DATA   = 3'd4;
    localparam state_t ST_ID     = 3'd5;
    localparam state_t ST_IGNORE = 3'd6;

    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[23:16];
            2'd1:    b = id[15:8];
            default: b = id[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives sck/csb edge pulses.
module spi_pin_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic RSTB,
    input  logic csb_i,
    input  logic sck_i,
    input  logic mosi_i,
    output logic csb_o,
    output logic mosi_o,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic csb_fall_o,
    output logic csb_rise_o
);

    logic [SYNC_STG-1:0] csb_q;
    logic [SYNC_STG-1:0] sck_q;
    logic [SYNC_STG-1:0] mosi_q;
    logic                csb_prev_q;
    logic                sck_prev_q;

    // Synchronizer chains plus one extra flop per control pin for edge detection.
    always_ff @(posedge clk) begin
        if (RSTB) begin
            csb_q      <= {SYNC_STG{1'b1}};
            sck_q      <= {SYNC_STG{1'b0}};
            mosi_q     <= {SYNC_STG{1'b0}};
            csb_prev_q <= 1'b1;
            sck_prev_q <= 1'b0;
        end else begin
            csb_q      <= {csb_q[SYNC_STG-2:0], csb_i};
            sck_q      <= {sck_q[SYNC_STG-2:0], sck_i};
            mosi_q     <= {mosi_q[SYNC_STG-2:0], mosi_i};
            csb_prev_q <= csb_q[SYNC_STG-1];
            sck_prev_q <= sck_q[SYNC_STG-1];
        end
    end

    assign csb_o      = csb_q[SYNC_STG-1];
    assign mosi_o     = mosi_q[SYNC_STG-1];
    // sck activity while deselected never reaches the FSM.
    assign sck_rise_o = sck_q[SYNC_STG-1] & ~sck_prev_q & ~csb_o;
    assign sck_fall_o = ~sck_q[SYNC_STG-1] & sck_prev_q & ~csb_o;
    assign csb_fall_o = ~csb_o & csb_prev_q;
    assign csb_rise_o = csb_o & ~csb_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI-flash responder (mode 0): READ 0x03 and JEDEC-ID 0x9F served from a synchronous memory port.
// Define SPI_FLASH_FASTREAD_EN to also accept FAST READ 0x0B with 8 dummy clocks.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter int          SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              RSTB,
    input  logic              spi_csb,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    logic csb_s, mosi_s, sck_rise_s, sck_fall_s, csb_fall_s, csb_rise_s;

    spi_pin_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .clk        (clk),
        .RSTB       (RSTB),
        .csb_i      (spi_csb),
        .sck_i      (spi_sck),
        .mosi_i     (spi_mosi),
        .csb_o      (csb_s),
        .mosi_o     (mosi_s),
        .sck_rise_o (sck_rise_s),
        .sck_fall_o (sck_fall_s),
        .csb_fall_o (csb_fall_s),
        .csb_rise_o (csb_rise_s)
    );

    state_t            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [22:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        tx_q, tx_d;
    logic [2:0]        tx_cnt_q, tx_cnt_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              miso_q, miso_d, oe_q, oe_d;
    logic              rd_q, rd_d, rd_dly_q, err_q, err_d, busy_q;
    logic [7:0]        buf_q;
    logic [23:0]       shift_in_s;
    logic [7:0]        byte_src_s, id_byte_s;
`ifdef SPI_FLASH_FASTREAD_EN
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_BITS - 1);
    logic fast_q, fast_d;
`endif

    assign shift_in_s = {shift_q, mosi_s};
    // The first byte after ADDR is needed before it has settled into buf_q.
    assign byte_src_s = rd_dly_q ? mem_rdata : buf_q;
    assign id_byte_s  = id_byte(JEDEC_ID, id_idx_q);

    // Next-state logic for the command FSM, shifters and address counter.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        tx_cnt_d  = tx_cnt_q;
        id_idx_d  = id_idx_q;
        miso_d    = miso_q;
        rd_d      = 1'b0;
        err_d     = 1'b0;
`ifdef SPI_FLASH_FASTREAD_EN
        fast_d    = fast_q;
`endif
        if (csb_s || csb_rise_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            tx_cnt_d  = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csb_fall_s) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 5'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_s) begin
                        shift_d = shift_in_s[22:0];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            tx_cnt_d  = 3'd0;
                            id_idx_d  = 2'd0;
`ifdef SPI_FLASH_FASTREAD_EN
                            fast_d    = (shift_in_s[7:0] == OP_FAST);
`endif
                            case (shift_in_s[7:0])
                                OP_READ:  state_d = ST_ADDR;
                                OP_JEDEC: state_d = ST_ID;
`ifdef SPI_FLASH_FASTREAD_EN
                                OP_FAST:  state_d = ST_ADDR;
`endif
                                default: begin
                                    state_d = ST_IGNORE;
                                    err_d   = 1'b1;
                                end
                            endcase
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_s) begin
                        shift_d = shift_in_s[22:0];
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            tx_cnt_d  = 3'd0;
                            addr_d    = shift_in_s[ADDR_W-1:0];
                            rd_d      = 1'b1;
`ifdef SPI_FLASH_FASTREAD_EN
                            state_d   = fast_q ? ST_DUMMY : ST_DATA;
`else
                            state_d   = ST_DATA;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
`ifdef SPI_FLASH_FASTREAD_EN
                ST_DUMMY: begin
                    if (sck_rise_s) begin
                        if (bit_cnt_q == DUMMY_LAST) begin
                            bit_cnt_d = 5'd0;
                            state_d   = ST_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
`endif
                ST_DATA: begin
                    if (sck_fall_s) begin
                        if (tx_cnt_q == 3'd0) begin
                            miso_d   = byte_src_s[7];
                            tx_d     = byte_src_s[6:0];
                            tx_cnt_d = 3'd7;
                            addr_d   = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            rd_d     = 1'b1;
                        end else begin
                            miso_d   = tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b0};
                            tx_cnt_d = tx_cnt_q - 3'd1;
                        end
                    end else begin
                        miso_d = miso_q;
                    end
                end
                ST_ID: begin
                    if (sck_fall_s) begin
                        if (tx_cnt_q == 3'd0) begin
                            miso_d   = id_byte_s[7];
                            tx_d     = id_byte_s[6:0];
                            tx_cnt_d = 3'd7;
                            id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                        end else begin
                            miso_d   = tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b0};
                            tx_cnt_d = tx_cnt_q - 3'd1;
                        end
                    end else begin
                        miso_d = miso_q;
                    end
                end
                ST_IGNORE: state_d = ST_IGNORE;
                default:   state_d = ST_IDLE;
            endcase
        end
        oe_d = (state_d == ST_DATA) || (state_d == ST_ID);
    end

    // State registers; MISO is forced low whenever the output is not enabled.
    always_ff @(posedge clk) begin
        if (RSTB) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 5'd0;
            shift_q   <= 23'd0;
            addr_q    <= {ADDR_W{1'b0}};
            tx_q      <= 7'd0;
            tx_cnt_q  <= 3'd0;
            id_idx_q  <= 2'd0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            rd_q      <= 1'b0;
            rd_dly_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            buf_q     <= 8'd0;
`ifdef SPI_FLASH_FASTREAD_EN
            fast_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            tx_cnt_q  <= tx_cnt_d;
            id_idx_q  <= id_idx_d;
            miso_q    <= miso_d & oe_d;
            oe_q      <= oe_d;
            rd_q      <= rd_d;
            rd_dly_q  <= rd_q;
            err_q     <= err_d;
            busy_q    <= ~csb_s;
            buf_q     <= rd_dly_q ? mem_rdata : buf_q;
`ifdef SPI_FLASH_FASTREAD_EN
            fast_q    <= fast_d;
`endif
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_addr    = addr_q;
    assign mem_rd      = rd_q;
    assign busy        = busy_q;
    assign cmd_err     = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench: a 24-bit and an 8-bit-address responder share the SPI pins, run at clk/sck = 4 and 12.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic RSTB = 1'b1, spi_csb = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
    logic miso, oe, rd, busy, err, miso8, oe8, rd8, busy8, err8;
    logic [23:0] maddr;
    logic [7:0]  maddr8;
    logic [7:0]  rdata = 8'h00, rdata8 = 8'h00;

    spi_flash_responder dut (
        .clk(clk), .RSTB(RSTB), .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(miso), .spi_miso_oe(oe), .mem_addr(maddr), .mem_rd(rd),
        .mem_rdata(rdata), .busy(busy), .cmd_err(err)
    );

    spi_flash_responder #(.ADDR_W(8)) dut8 (
        .clk(clk), .RSTB(RSTB), .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(miso8), .spi_miso_oe(oe8), .mem_addr(maddr8), .mem_rd(rd8),
        .mem_rdata(rdata8), .busy(busy8), .cmd_err(err8)
    );

    logic [7:0] mem [256];
    logic [7:0] log8 [64];
    int rd_cnt = 0, rd8_cnt = 0, err_cnt = 0, err8_cnt = 0, log8_n = 0;

    // Memory model (data valid the clk after mem_rd) and strobe counters.
    always @(posedge clk) begin
        if (rd) begin
            rdata  <= mem[maddr[7:0]];
            rd_cnt <= rd_cnt + 1;
        end
        if (rd8) begin
            rdata8  <= mem[maddr8];
            rd8_cnt <= rd8_cnt + 1;
            if (log8_n < 64) begin
                log8[log8_n] <= maddr8;
                log8_n       <= log8_n + 1;
            end
        end
        if (err)  err_cnt  <= err_cnt + 1;
        if (err8) err8_cnt <= err8_cnt + 1;
    end

    typedef struct {
        logic [7:0]  op;
        logic        has_addr;
        int          ndummy;
        logic [23:0] addr;
        int          nbytes;
        logic [47:0] exp_data;
        int          exp_rd;
        int          exp_err;
        logic        exp_oe;
    } vec_t;

    vec_t vecs [6];
    int applied = 0, miscompares = 0, hp = 2, last_l0 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (half period %0d clks)", name, act, exp, hp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit; MISO is sampled late in the high phase to absorb the synchronizer delay.
    task automatic bit_clk(input logic b, input bit end_cs, output logic r, output logic r8);
        spi_mosi = b;
        wait_clk(hp);
        spi_sck = 1'b1;
        wait_clk(hp);
        r  = miso;
        r8 = miso8;
        if (end_cs) spi_csb = 1'b1;
        spi_sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, input bit end_cs, output logic [7:0] rx, output logic [7:0] rx8);
        logic r, r8;
        for (int b = 7; b >= 0; b--) begin
            bit_clk(tx[b], end_cs && (b == 0), r, r8);
            rx[b]  = r;
            rx8[b] = r8;
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int rd0, rd80, e0, e80;
        logic [7:0] r, r8, eb;
        v = vecs[idx];
        rd0 = rd_cnt; rd80 = rd8_cnt; e0 = err_cnt; e80 = err8_cnt; last_l0 = log8_n;
        spi_csb = 1'b0;
        wait_clk(hp);
        chk($sformatf("oe_pre[%0d]", idx), {62'd0, oe, oe8}, 64'd0);
        xfer(v.op, 1'b0, r, r8);
        if (v.has_addr) begin
            xfer(v.addr[23:16], 1'b0, r, r8);
            xfer(v.addr[15:8], 1'b0, r, r8);
            xfer(v.addr[7:0], 1'b0, r, r8);
        end
        for (int d = 0; d < v.ndummy; d++) xfer(8'h00, 1'b0, r, r8);
        wait_clk(2);
        chk($sformatf("oe_hdr[%0d]", idx), {62'd0, oe, oe8}, {62'd0, v.exp_oe, v.exp_oe});
        for (int i = 0; i < v.nbytes; i++) begin
            xfer(8'h00, i == v.nbytes - 1, r, r8);
            eb = v.exp_data[47 - 8*i -: 8];
            chk($sformatf("miso[%0d].%0d", idx, i), {56'd0, r}, {56'd0, eb});
            chk($sformatf("miso8[%0d].%0d", idx, i), {56'd0, r8}, {56'd0, eb});
        end
        wait_clk(6);
        chk($sformatf("idle[%0d]", idx), {60'd0, busy, oe, busy8, oe8}, 64'd0);
        chk($sformatf("mem_rd[%0d]", idx), 64'(rd_cnt - rd0), 64'(v.exp_rd));
        chk($sformatf("mem_rd8[%0d]", idx), 64'(rd8_cnt - rd80), 64'(v.exp_rd));
        chk($sformatf("cmd_err[%0d]", idx), 64'(err_cnt - e0), 64'(v.exp_err));
        chk($sformatf("cmd_err8[%0d]", idx), 64'(err8_cnt - e80), 64'(v.exp_err));
    endtask

    initial begin
        logic [7:0] r, r8;
        logic       b, b8;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5; mem[8'h11] = 8'h5A; mem[8'h12] = 8'h01; mem[8'h13] = 8'hFF;
        mem[8'h00] = 8'h3C; mem[8'h01] = 8'hC3;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22;
        mem[8'h20] = 8'h77; mem[8'h21] = 8'h88;

        vecs[0] = '{OP_READ,  1'b1, 0, 24'h000010, 4, 48'hA55A01FF0000, 5, 0, 1'b1};
        vecs[1] = '{OP_JEDEC, 1'b0, 0, 24'h000000, 6, 48'hEF4016EF4016, 0, 0, 1'b1};
        vecs[2] = '{8'h55,    1'b0, 0, 24'h000000, 1, 48'h000000000000, 0, 1, 1'b0};
        vecs[3] = '{OP_READ,  1'b1, 0, 24'h000000, 2, 48'h3CC300000000, 3, 0, 1'b1};
        vecs[4] = '{OP_READ,  1'b1, 0, 24'h0000FE, 3, 48'h11223C000000, 4, 0, 1'b1};
`ifdef SPI_FLASH_FASTREAD_EN
        vecs[5] = '{OP_FAST,  1'b1, 1, 24'h000020, 2, 48'h778800000000, 3, 0, 1'b1};
`else
        vecs[5] = '{OP_FAST,  1'b1, 1, 24'h000020, 2, 48'h000000000000, 0, 1, 1'b0};
`endif

        for (int k = 0; k < 2; k++) begin
            hp = (k == 0) ? 2 : 6;
            RSTB = 1'b1; spi_csb = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
            wait_clk(4);
            chk("reset", {22'd0, miso, oe, rd, busy, err, maddr, miso8, oe8, rd8, busy8, err8, maddr8}, 64'd0);
            RSTB = 1'b0;
            wait_clk(4);

            for (int i = 0; i < 6; i++) begin
                if (i == 3) begin
                    // READ abandoned after 13 address bits; the next READ must start clean.
                    spi_csb = 1'b0;
                    wait_clk(hp);
                    xfer(OP_READ, 1'b0, r, r8);
                    for (int j = 0; j < 13; j++) bit_clk(1'b1, 1'b0, b, b8);
                    spi_csb = 1'b1;
                    wait_clk(6);
                    chk("abort_idle", {62'd0, busy, busy8}, 64'd0);
                end
                run_vec(i);
                if (i == 4) begin
                    chk("wrap_addr0", {56'd0, log8[last_l0]},     64'h00FE);
                    chk("wrap_addr1", {56'd0, log8[last_l0 + 1]}, 64'h00FF);
                    chk("wrap_addr2", {56'd0, log8[last_l0 + 2]}, 64'h0000);
                end
            end

            // Reset asserted in the middle of a data byte.
            spi_csb = 1'b0;
            wait_clk(hp);
            xfer(OP_READ, 1'b0, r, r8);
            xfer(8'h00, 1'b0, r, r8);
            xfer(8'h00, 1'b0, r, r8);
            xfer(8'h10, 1'b0, r, r8);
            xfer(8'h00, 1'b0, r, r8);
            chk("rst_pre_data", {56'd0, r}, 64'h00A5);
            chk("rst_pre_busy", {63'd0, busy}, 64'd1);
            for (int j = 0; j < 3; j++) bit_clk(1'b0, 1'b0, b, b8);
            RSTB = 1'b1;
            wait_clk(1);
            chk("rst_mid", {22'd0, miso, oe, rd, busy, err, maddr, miso8, oe8, rd8, busy8, err8, maddr8}, 64'd0);
            spi_csb = 1'b1;
            wait_clk(4);
            RSTB = 1'b0;
            wait_clk(4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
